// File: rtl/cb_trace_writer_pkg.sv
// Shared types for the circular-buffer trace writer.
package cb_trace_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int unsigned OutstWidth = 2;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO; 1-cycle push-to-pop latency (0 with FALL_THROUGH).
// Push ignored when full, pop ignored when empty; flush empties in one cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LastIdx  = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   DepthCnt = (ADDR_DEPTH + 1)'(DEPTH);

  logic [ADDR_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;

  // A full power-of-two FIFO reports usage 0; full_o disambiguates.
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    mem_we = 1'b0;
    data_o = mem_q[rd_q];
    if (push_i && !full_o) begin
      mem_we = 1'b1;
      wr_d   = (wr_q == LastIdx) ? '0 : wr_q + ADDR_DEPTH'(1);
      cnt_d  = cnt_d + (ADDR_DEPTH + 1)'(1);
    end
    if (pop_i && !empty_o) begin
      rd_d  = (rd_q == LastIdx) ? '0 : rd_q + ADDR_DEPTH'(1);
      cnt_d = cnt_d - (ADDR_DEPTH + 1)'(1);
    end
    if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        cnt_d  = cnt_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        mem_we = 1'b0;
      end
    end
    if (flush_i) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cb_trace_writer.sv
// Streams trace words into the circular buffer over TCDM; word to req_o latency 1 cycle.
// data_ready_o drops when the FIFO is full; in stop-when-full mode words are accepted and counted as dropped.
module cb_trace_writer
  import cb_trace_writer_pkg::*;
#(
  parameter int unsigned NumWords  = 4096,
  parameter int unsigned AddrWidth = $clog2(NumWords),
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   mode_i,
  input  logic                   clear_i,
  input  logic                   data_valid_i,
  input  logic [DataWidth-1:0]   data_i,
  output logic                   data_ready_o,
  output logic                   req_o,
  output logic [AddrWidth-1:0]   add_o,
  output logic                   wen_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [DataWidth/8-1:0] be_o,
  input  logic                   gnt_i,
  input  logic                   r_valid_i,
  output logic [AddrWidth-1:0]   wr_ptr_o,
  output logic                   wrapped_o,
  output logic                   full_o,
  output logic [CntWidth-1:0]    dropped_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned          FifoAw   = $clog2(FifoDepth);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  state_e                state_q;
  logic                  mode_q, done_q;
  logic [AddrWidth-1:0]  ptr_q, ptr_d;
  logic                  wrapped_q, wrapped_d, full_q, full_d, err_q, err_d;
  logic [CntWidth-1:0]   drop_q, drop_d;
  logic [OutstWidth-1:0] outst_q, outst_d;

  logic                  fifo_full, fifo_empty, accept, push, gnt_ok, do_clear;
  logic [FifoAw-1:0]     fifo_usage;
  logic [DataWidth-1:0]  fifo_head;
  logic [FifoAw:0]       n_drop;
  logic [CntWidth:0]     drop_sum;

  assign do_clear     = (state_q == IDLE) & clear_i;
  assign data_ready_o = (state_q == RUN) & enable_i & (full_q | ~fifo_full);
  assign accept       = data_valid_i & data_ready_o;
  assign push         = accept & ~full_q;
  assign req_o        = ~fifo_empty & ~full_q;
  assign gnt_ok       = req_o & gnt_i;

  assign add_o     = ptr_q;
  assign wdata_o   = req_o ? fifo_head : '0;
  assign wen_o     = req_o;
  assign be_o      = '1;
  assign wr_ptr_o  = ptr_q;
  assign wrapped_o = wrapped_q;
  assign full_o    = full_q;
  assign dropped_o = drop_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DataWidth),
    .DEPTH        (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (full_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (data_i),
    .push_i  (push),
    .data_o  (fifo_head),
    .pop_i   (gnt_ok)
  );

  // Once full, whatever sits in the FIFO plus every newly accepted word is discarded.
  assign n_drop   = full_q ? ({fifo_full, fifo_usage} + (FifoAw + 1)'(accept)) : '0;
  assign drop_sum = {1'b0, drop_q} + (CntWidth + 1)'(n_drop);

  always_comb begin
    ptr_d     = ptr_q;
    wrapped_d = wrapped_q;
    full_d    = full_q;
    err_d     = err_q;
    outst_d   = outst_q;
    drop_d    = drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
    if (gnt_ok) begin
      if (ptr_q == LastAddr) begin
        if (mode_q) begin
          full_d = 1'b1;
        end else begin
          ptr_d     = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        ptr_d = ptr_q + AddrWidth'(1);
      end
    end
    if (r_valid_i && (outst_q == '0)) err_d = 1'b1;
    if (gnt_ok && !r_valid_i) begin
      outst_d = outst_q + OutstWidth'(1);
    end else if (r_valid_i && !gnt_ok && (outst_q != '0)) begin
      outst_d = outst_q - OutstWidth'(1);
    end
    if (do_clear) begin
      ptr_d     = '0;
      wrapped_d = 1'b0;
      full_d    = 1'b0;
      drop_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      wrapped_q <= 1'b0;
      full_q    <= 1'b0;
      drop_q    <= '0;
      err_q     <= 1'b0;
      outst_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wrapped_q <= wrapped_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      outst_q   <= outst_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q <= RUN;
            mode_q  <= mode_i;
          end
        end
        RUN: begin
          if (!enable_i) state_q <= DRAIN;
        end
        DRAIN: begin
          // Leave only once the last response has landed, so done_o means all writes are committed.
          if (fifo_empty && (outst_d == '0)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_trace_writer.sv
// Directed bench for cb_trace_writer with a latency-1 TCDM responder and write monitor.
module tb_cb_trace_writer;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4096;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_ni, enable_i, mode_i, clear_i, data_valid_i, gnt_i, r_valid_i;
  logic [DW-1:0] data_i, wdata_o;
  logic          data_ready_o, req_o, wen_o, wrapped_o, full_o, busy_o, done_o, err_o;
  logic [AW-1:0] add_o, wr_ptr_o;
  logic [3:0]    be_o;
  logic [CW-1:0] dropped_o;

  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  last_rv_cyc = -10;
  logic rv_pend = 1'b0;
  wr_t wq[$];

  cb_trace_writer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .clear_i      (clear_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .req_o        (req_o),
    .add_o        (add_o),
    .wen_o        (wen_o),
    .wdata_o      (wdata_o),
    .be_o         (be_o),
    .gnt_i        (gnt_i),
    .r_valid_i    (r_valid_i),
    .wr_ptr_o     (wr_ptr_o),
    .wrapped_o    (wrapped_o),
    .full_o       (full_o),
    .dropped_o    (dropped_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Responder: one write response per granted request, one cycle later.
  always @(posedge clk) begin
    cyc++;
    #1 r_valid_i = rv_pend;
  end

  always @(negedge clk) begin
    if (r_valid_i) last_rv_cyc = cyc;
    if (rst_ni && req_o && gnt_i) wq.push_back('{a: add_o, d: wdata_o});
    rv_pend = req_o & gnt_i & rst_ni;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; enable_i = 1'b0; mode_i = 1'b0; clear_i = 1'b0;
    data_valid_i = 1'b0; data_i = '0; gnt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    wq.delete();
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    data_valid_i = 1'b1;
    data_i = d;
    @(negedge clk);
    while (!data_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready_o) chk("push_rdy", data_ready_o, 1);
    @(posedge clk);
    #1 data_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit chk_dly);
    int n = 0;
    @(negedge clk);
    while (!done_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done_o, 1);
    if (chk_dly) chk({tag, "_done_dly"}, cyc - last_rv_cyc, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  initial begin
    r_valid_i = 1'b0;
    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_req", req_o, 0);
    chk("rst_add", add_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wen", wen_o, 0);
    chk("rst_be", be_o, 4'hF);
    chk("rst_rdy", data_ready_o, 0);
    chk("rst_ptr", wr_ptr_o, 0);
    chk("rst_flags", {wrapped_o, full_o, busy_o, done_o, err_o}, 0);
    chk("rst_drop", dropped_o, 0);

    // Basic three-word run with grant tied high
    @(posedge clk); #1 enable_i = 1'b1; gnt_i = 1'b1;
    push(32'hA0); push(32'hA1); push(32'hA2);
    enable_i = 1'b0;
    wait_done("t1", 1'b1);
    chk("t1_nwr", wq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_add", wq[i].a, i);
      chk("t1_dat", wq[i].d, 32'hA0 + i);
    end
    chk("t1_ptr", wr_ptr_o, 3);

    // Grant held low: FIFO fills, request held stable
    do_reset();
    enable_i = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hB0 + i);
    data_valid_i = 1'b1; data_i = 32'hB4;
    @(negedge clk);
    chk("t2_rdy_full", data_ready_o, 0);
    chk("t2_req", req_o, 1);
    chk("t2_add", add_o, 0);
    chk("t2_wdata", wdata_o, 32'hB0);
    @(negedge clk);
    chk("t2_add_hold", add_o, 0);
    chk("t2_wdata_hold", wdata_o, 32'hB0);
    chk("t2_nwr_stall", wq.size(), 0);
    @(posedge clk); #1 gnt_i = 1'b1;
    push(32'hB4); push(32'hB5);
    enable_i = 1'b0;
    wait_done("t2", 1'b1);
    chk("t2_nwr", wq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_add_i", wq[i].a, i);
      chk("t2_dat_i", wq[i].d, 32'hB0 + i);
    end

    // Mode 0 wrap
    do_reset();
    enable_i = 1'b1; gnt_i = 1'b1;
    for (int i = 0; i < NW + 2; i++) push(i);
    enable_i = 1'b0;
    wait_done("t3", 1'b1);
    chk("t3_nwr", wq.size(), NW + 2);
    chk("t3_add_last", wq[NW-1].a, NW - 1);
    chk("t3_add_wrap0", wq[NW].a, 0);
    chk("t3_dat_wrap0", wq[NW].d, NW);
    chk("t3_add_wrap1", wq[NW+1].a, 1);
    chk("t3_wrapped", wrapped_o, 1);
    chk("t3_ptr", wr_ptr_o, 2);
    chk("t3_full", full_o, 0);
    chk("t3_drop", dropped_o, 0);
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    @(negedge clk);
    chk("t3_clr_ptr", wr_ptr_o, 0);
    chk("t3_clr_wrapped", wrapped_o, 0);

    // Mode 1 stop-when-full
    do_reset();
    mode_i = 1'b1; enable_i = 1'b1; gnt_i = 1'b1;
    for (int i = 0; i < NW + 3; i++) push(i);
    @(negedge clk);
    chk("t4_req_stop", req_o, 0);
    enable_i = 1'b0;
    wait_done("t4", 1'b0);
    chk("t4_nwr", wq.size(), NW);
    chk("t4_add_last", wq[NW-1].a, NW - 1);
    chk("t4_full", full_o, 1);
    chk("t4_drop", dropped_o, 3);
    chk("t4_ptr", wr_ptr_o, NW - 1);
    chk("t4_wrapped", wrapped_o, 0);
    // Clear and enable together: clear applies, then run
    @(posedge clk); #1 clear_i = 1'b1; enable_i = 1'b1; mode_i = 1'b0;
    @(posedge clk); #1 clear_i = 1'b0;
    @(negedge clk);
    chk("t4_ce_busy", busy_o, 1);
    chk("t4_ce_full", full_o, 0);
    chk("t4_ce_drop", dropped_o, 0);
    chk("t4_ce_ptr", wr_ptr_o, 0);
    @(posedge clk); #1 enable_i = 1'b0;
    wait_done("t4b", 1'b0);

    // Disable with two words queued and grant low
    do_reset();
    enable_i = 1'b1;
    push(32'hC0); push(32'hC1);
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_busy", busy_o, 1);
      chk("t5_nodone", done_o, 0);
      chk("t5_rdy", data_ready_o, 0);
    end
    @(posedge clk); #1 gnt_i = 1'b1;
    wait_done("t5", 1'b1);
    chk("t5_nwr", wq.size(), 2);
    chk("t5_dat0", wq[0].d, 32'hC0);
    chk("t5_dat1", wq[1].d, 32'hC1);
    chk("t5_add1", wq[1].a, 1);

    // Reset while a request is pending
    do_reset();
    enable_i = 1'b1;
    push(32'hD0);
    @(negedge clk);
    chk("t6_req_pre", req_o, 1);
    @(posedge clk); #1 rst_ni = 1'b0; enable_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_req", req_o, 0);
    chk("t6_wen", wen_o, 0);
    chk("t6_wdata", wdata_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_rdy", data_ready_o, 0);
    @(posedge clk); #1 rst_ni = 1'b1; gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_req_post", req_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_done", done_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
